// File: rtl/reg_file_pkg.sv
// Shared defaults and write-request type for the multi-port register file.
// Request fields are sized for the widest supported configuration.
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;

    localparam int REQ_ADDR_W = 16;
    localparam int REQ_DATA_W = 64;

    typedef struct packed {
        logic                  en;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic addr_ok(input int unsigned addr,
                                     input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_file_wr_arb.sv
// Resolves same-cycle write requests into per-register enable and data.
// Later (higher-index) ports override earlier ones on an address clash.
module reg_file_wr_arb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_WR = 2
) (
    input  wr_req_t                    reqs [NUM_WR],
    output logic [DEPTH-1:0]           we,
    output logic [DEPTH-1:0][DATA_W-1:0] wdata
);

    logic unused_par;

    always_comb begin
        we         = '0;
        wdata      = '0;
        unused_par = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (reqs[i].en && reqs[i].addr == REQ_ADDR_W'(r)) begin
                    we[r]    = 1'b1;
                    wdata[r] = reqs[i].data[DATA_W-1:0];
                end
            end
        end
        // pad bits above DATA_W carry no information
        for (int i = 0; i < NUM_WR; i++) begin
            unused_par = unused_par ^ (^reqs[i].data);
        end
    end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port register file with a pending-write scoreboard.
// Same-cycle write-to-read bypass is enabled by MP_REG_FILE_BYPASS_EN.
module mp_reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  write_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  write_data,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  read_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  read_data,
    output logic [NUM_RD-1:0]              read_ready,
    input  logic                           pend_en,
    input  logic [ADDR_W-1:0]              pend_addr,
    output logic                           pend_busy
);

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             pending;
    logic [DEPTH-1:0]             reg_we;
    logic [DEPTH-1:0][DATA_W-1:0] reg_wdata;
    logic [DEPTH-1:0]             pend_set;
    wr_req_t                      reqs [NUM_WR];

    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            reqs[i].en   = wr_en[i];
            reqs[i].addr = REQ_ADDR_W'(write_addr[i]);
            reqs[i].data = REQ_DATA_W'(write_data[i]);
        end
    end

    reg_file_wr_arb #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR)
    ) u_wr_arb (
        .reqs   (reqs),
        .we     (reg_we),
        .wdata  (reg_wdata)
    );

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            pend_set[r] = pend_en && (pend_addr == ADDR_W'(r));
        end
    end

    // a new producer marking the register outranks the write retiring it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (reg_we[r]) regs[r] <= reg_wdata[r];
                if (pend_set[r]) pending[r] <= 1'b1;
                else if (reg_we[r]) pending[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            read_data[j]  = '0;
            read_ready[j] = 1'b1;
            if (addr_ok(32'(read_addr[j]), DEPTH)) begin
                read_data[j]  = regs[read_addr[j]];
                read_ready[j] = !pending[read_addr[j]];
`ifdef MP_REG_FILE_BYPASS_EN
                if (!reset && reg_we[read_addr[j]]) begin
                    read_data[j]  = reg_wdata[read_addr[j]];
                    read_ready[j] = 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        pend_busy = 1'b0;
        if (pend_en && addr_ok(32'(pend_addr), DEPTH)) begin
            pend_busy = pending[pend_addr];
        end
    end

endmodule

// File: tb/tb_mp_reg_file.sv
// Scoreboard bench for mp_reg_file: a reference model predicts read ports
// and pend_busy each cycle; predictions are queued and compared at sampling.
module tb_mp_reg_file;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NW-1:0]         wr_en;
    logic [NW-1:0][AW-1:0] write_addr;
    logic [NW-1:0][DW-1:0] write_data;
    logic [NR-1:0][AW-1:0] read_addr;
    logic [NR-1:0][DW-1:0] read_data;
    logic [NR-1:0]         read_ready;
    logic                  pend_en;
    logic [AW-1:0]         pend_addr;
    logic                  pend_busy;

    mp_reg_file #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .NUM_RD (NR),
        .NUM_WR (NW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_ready (read_ready),
        .pend_en    (pend_en),
        .pend_addr  (pend_addr),
        .pend_busy  (pend_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        int            kind;
        int            port;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] mregs [DP];
    bit            mpend [DP];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < DP; r++) begin
            mregs[r] = '0;
            mpend[r] = 1'b0;
        end
    endtask

    task automatic predict(input string tag);
        logic [DW-1:0] d;
        logic          rdy;
        if (reset) model_clear();
        for (int j = 0; j < NR; j++) begin
            d   = mregs[read_addr[j]];
            rdy = !mpend[read_addr[j]];
`ifdef MP_REG_FILE_BYPASS_EN
            for (int i = 0; i < NW; i++) begin
                if (!reset && wr_en[i] && write_addr[i] == read_addr[j]) begin
                    d   = write_data[i];
                    rdy = 1'b1;
                end
            end
`endif
            sb.push_back('{tag, 0, j, d});
            sb.push_back('{tag, 1, j, DW'(rdy)});
        end
        sb.push_back('{tag, 2, 0, DW'(pend_en && mpend[pend_addr])});
    endtask

    task automatic drain();
        exp_t          e;
        logic [DW-1:0] obs;
        string         nm;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0: begin
                    obs = read_data[e.port];
                    nm  = $sformatf("%s.data%0d", e.tag, e.port);
                end
                1: begin
                    obs = DW'(read_ready[e.port]);
                    nm  = $sformatf("%s.ready%0d", e.tag, e.port);
                end
                default: begin
                    obs = DW'(pend_busy);
                    nm  = $sformatf("%s.busy", e.tag);
                end
            endcase
            check(nm, obs, e.exp);
        end
    endtask

    task automatic commit();
        if (!reset) begin
            for (int i = 0; i < NW; i++) begin
                if (wr_en[i]) begin
                    mregs[write_addr[i]] = write_data[i];
                    mpend[write_addr[i]] = 1'b0;
                end
            end
            if (pend_en) mpend[pend_addr] = 1'b1;
        end
    endtask

    task automatic step(input string tag);
        predict(tag);
        #1;
        drain();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en   = '0;
        pend_en = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = '0;
        write_addr = '0;
        write_data = '0;
        read_addr  = '0;
        pend_en    = 1'b0;
        pend_addr  = '0;
        model_clear();
        @(negedge clk);
        read_addr[1] = 4'd3;
        step("rst");

        reset = 1'b0;
        step("idle");

        wr_en         = 2'b01;
        write_addr[0] = 4'd3;
        write_data[0] = 32'd5;
        step("w3");
        idle();
        step("r3");

        wr_en         = 2'b11;
        write_addr[0] = 4'd4;
        write_addr[1] = 4'd4;
        write_data[0] = 32'd12;
        write_data[1] = 32'd13;
        read_addr[0]  = 4'd4;
        step("w4dual");
        idle();
        step("r4");

        wr_en         = 2'b01;
        write_addr[0] = 4'd5;
        write_data[0] = 32'd10;
        read_addr[0]  = 4'd5;
        step("byp5");
        idle();
        step("r5");

        pend_en      = 1'b1;
        pend_addr    = 4'd7;
        read_addr[0] = 4'd7;
        read_addr[1] = 4'd7;
        step("pend7");
        step("pend7b");
        pend_en       = 1'b0;
        wr_en         = 2'b01;
        write_addr[0] = 4'd7;
        write_data[0] = 32'd11;
        step("w7");
        idle();
        step("r7");

        pend_en       = 1'b1;
        pend_addr     = 4'd8;
        wr_en         = 2'b10;
        write_addr[1] = 4'd8;
        write_data[1] = 32'h88;
        read_addr[0]  = 4'd8;
        step("setclr8");
        idle();
        step("r8");

        repeat (150) begin
            wr_en         = NW'($urandom);
            write_addr[0] = AW'($urandom_range(0, DP - 1));
            write_addr[1] = AW'($urandom_range(0, DP - 1));
            write_data[0] = $urandom;
            write_data[1] = $urandom;
            pend_en       = ($urandom_range(0, 3) == 0);
            pend_addr     = AW'($urandom_range(0, DP - 1));
            read_addr[0]  = AW'($urandom_range(0, DP - 1));
            read_addr[1]  = AW'($urandom_range(0, DP - 1));
            step("rnd");
        end
        idle();
        for (int r = 0; r < DP; r += 2) begin
            read_addr[0] = AW'(r);
            read_addr[1] = AW'(r + 1);
            step("sweep");
        end

        wr_en         = 2'b01;
        write_addr[0] = 4'd2;
        write_data[0] = 32'd5;
        read_addr[0]  = 4'd2;
        read_addr[1]  = 4'd2;
        step("w2");
        idle();
        pend_en   = 1'b1;
        pend_addr = 4'd2;
        step("p2");
        idle();
        step("chk2");
        reset         = 1'b1;
        wr_en         = 2'b01;
        write_addr[0] = 4'd2;
        write_data[0] = 32'h77;
        pend_en       = 1'b1;
        step("rst_mid");
        step("rst_hold");
        reset = 1'b0;
        idle();
        step("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_reg_file.md
MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of registers; ADDR_W = $clog2(DEPTH).
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of read ports.
REQ-004 The block SHALL have parameter NUM_WR, default 2, meaning number of write ports.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port wr_en, input, [NUM_WR], per-port write enable.
REQ-008 The block SHALL have port write_addr, input, [NUM_WR][ADDR_W], per-port write address.
REQ-009 The block SHALL have port write_data, input, [NUM_WR][DATA_W], per-port write data.
REQ-010 The block SHALL have port read_addr, input, [NUM_RD][ADDR_W], per-port read address.
REQ-011 The block SHALL have port read_data, output, [NUM_RD][DATA_W], per-port read data.
REQ-012 The block SHALL have port read_ready, output, [NUM_RD], high when addressed register holds no outstanding pending write.
REQ-013 The block SHALL have port pend_en, input, 1, marks pend_addr as awaiting a future write.
REQ-014 The block SHALL have port pend_addr, input, ADDR_W, register to mark pending.
REQ-015 The block SHALL have port pend_busy, output, 1, high when pend_en targets an already-pending register.

Function
REQ-016 Write port i with wr_en[i]=1 SHALL update register write_addr[i] with write_data[i] at posedge clk.
REQ-017 When two or more enabled write ports share an address in one cycle, the block SHALL commit the highest-index port's data only.
REQ-018 Reads SHALL be combinational: read_data[j] reflects register read_addr[j] in the same cycle the address is applied.
REQ-019 A committed write SHALL be visible on every read port the cycle after the posedge that commits it.
REQ-020 pend_en=1 SHALL set pending[pend_addr] at posedge; an enabled write SHALL clear pending[write_addr] at posedge.
REQ-021 Simultaneous set and clear of the same address SHALL leave pending=1 (new producer wins).
REQ-022 read_ready[j] SHALL equal !pending[read_addr[j]], combinationally.
REQ-023 pend_busy SHALL equal pend_en & pending[pend_addr], combinationally; the set still occurs.
REQ-024 For DEPTH not a power of two, out-of-range writes/pends SHALL be ignored; out-of-range reads SHALL return 0 with read_ready=1.

Reset
REQ-025 While reset=1, all registers and pending bits SHALL be 0 regardless of clk; read_data=0, read_ready=1, pend_busy=pend_en & 0 = 0.
REQ-026 Writes and pends presented on a posedge where reset=1 SHALL be discarded; operation resumes on the first posedge after deassertion.

Configuration
REQ-027 With macro MP_REG_FILE_BYPASS_EN defined, a read whose address matches an enabled write in the same cycle SHALL return that write_data (highest-index matching port) and read_ready=1.
REQ-028 Without MP_REG_FILE_BYPASS_EN, reads SHALL return stored contents only (REQ-018/019) and read_ready per REQ-022.

Structure
REQ-029 A shared package reg_file_pkg SHALL hold default DATA_W/DEPTH constants and the write-request struct type (en, addr, data).
REQ-030 One sub-module, reg_file_wr_arb, SHALL resolve per-address write priority and produce per-register write enable/data; storage, scoreboard and read muxes stay in mp_reg_file.

Verification
REQ-031 Reset, then wr_en[0]=1, write_addr[0]=3, write_data[0]=5, read_addr[1]=3 -> read_data[1]=5 the cycle after the edge; 0 before it (no bypass).
REQ-032 Same cycle wr_en[0]/wr_en[1]=1, both addr 4, data 12/13 -> register 4 holds 13 next cycle.
REQ-033 With MP_REG_FILE_BYPASS_EN: write 10 to addr 5, read_addr[0]=5 same cycle -> read_data[0]=10 before the edge, read_ready[0]=1.
REQ-034 pend_en=1, pend_addr=7 -> read_ready=0 for addr 7 next cycle; second pend to 7 -> pend_busy=1; write 11 to 7 -> read_ready=1 and data 11 next cycle.
REQ-035 Write 5 to reg 2, then pend reg 2, assert reset between edges -> read_data=0, read_ready=1 immediately; write on a reset-high edge is not stored.
